// File: rtl/cr16_pkg.sv
// Shared constants for the CR16 datapath: widths, opcode encodings, flag bit positions.
package cr16_pkg;
  localparam int DW     = 16;
  localparam int NREGS  = 16;
  localparam int NFLAGS = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_RSH  = 4'd8;
  localparam logic [3:0] OP_ARSH = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int FLG_C = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  function automatic logic op_valid(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction
endpackage

// File: rtl/cr16_alu.sv
// Combinational CR16 ALU: result plus candidate flag values and a per-flag write mask.
module cr16_alu
  import cr16_pkg::*;
(
  input  logic [DW-1:0]     a_i,
  input  logic [DW-1:0]     b_i,
  input  logic [3:0]        op_i,
  output logic [DW-1:0]     result_o,
  output logic [NFLAGS-1:0] flags_o,
  output logic [NFLAGS-1:0] flag_we_o
);
  logic [DW:0]   sum, diff;
  logic [DW-1:0] prod;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = a_i * b_i;

  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_ADD:  result_o = sum[DW-1:0];
      OP_SUB:  result_o = diff[DW-1:0];
      OP_CMP:  result_o = a_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_LSH:  result_o = a_i << b_i[3:0];
      OP_RSH:  result_o = a_i >> b_i[3:0];
      OP_ARSH: result_o = $unsigned($signed(a_i) >>> b_i[3:0]);
      OP_MOV:  result_o = b_i;
      OP_LUI:  result_o = {b_i[7:0], 8'h00};
      OP_MUL:  result_o = prod;
      default: result_o = '0;
    endcase
  end

  // Mask selects which flags an opcode owns; unmasked flags keep their old value.
  always_comb begin
    flags_o   = '0;
    flag_we_o = '0;
    if (op_valid(op_i) && op_i != OP_CMP) begin
      flag_we_o[FLG_Z] = 1'b1;
      flag_we_o[FLG_N] = 1'b1;
      flags_o[FLG_Z]   = (result_o == '0);
      flags_o[FLG_N]   = result_o[DW-1];
    end
    if (op_i == OP_ADD) begin
      flag_we_o[FLG_C] = 1'b1;
      flag_we_o[FLG_F] = 1'b1;
      flags_o[FLG_C]   = sum[DW];
      flags_o[FLG_F]   = (a_i[DW-1] == b_i[DW-1]) && (result_o[DW-1] != a_i[DW-1]);
    end else if (op_i == OP_SUB) begin
      flag_we_o[FLG_C] = 1'b1;
      flag_we_o[FLG_F] = 1'b1;
      flags_o[FLG_C]   = diff[DW];
      flags_o[FLG_F]   = (a_i[DW-1] != b_i[DW-1]) && (result_o[DW-1] != a_i[DW-1]);
    end else if (op_i == OP_CMP) begin
      flag_we_o[FLG_Z] = 1'b1;
      flag_we_o[FLG_L] = 1'b1;
      flag_we_o[FLG_N] = 1'b1;
      flags_o[FLG_Z]   = (a_i == b_i);
      flags_o[FLG_L]   = (a_i < b_i);
      flags_o[FLG_N]   = ($signed(a_i) < $signed(b_i));
    end
  end
endmodule

// File: rtl/cr16_datapath.sv
// CR16 datapath: 16x16 register file with two read ports, ALU and status-flag register.
module cr16_datapath
  import cr16_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_ENABLE,
  input  logic [NREGS-1:0]  I_REG_ENABLE,
  input  logic [3:0]        I_OPCODE,
  input  logic [3:0]        I_READ_PORT_A_SEL,
  input  logic [3:0]        I_READ_PORT_B_SEL,
  input  logic [DW-1:0]     I_IMMEDIATE,
  input  logic              I_IMM_SEL,
  output logic [DW-1:0]     O_WRITE_PORT,
  output logic [NFLAGS-1:0] O_FLAGS
);
  logic [DW-1:0]     regs_q [NREGS];
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]     opa, opb;
  logic [NFLAGS-1:0] alu_flags, alu_we;

  assign opa = regs_q[I_READ_PORT_A_SEL];
  assign opb = I_IMM_SEL ? I_IMMEDIATE : regs_q[I_READ_PORT_B_SEL];

  cr16_alu u_alu (
    .a_i       (opa),
    .b_i       (opb),
    .op_i      (I_OPCODE),
    .result_o  (O_WRITE_PORT),
    .flags_o   (alu_flags),
    .flag_we_o (alu_we)
  );

  // Reserved opcodes produce an all-zero mask, so flags hold without an extra check.
  always_comb begin
    flags_d = flags_q;
    if (I_ENABLE) flags_d = (flags_q & ~alu_we) | (alu_flags & alu_we);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (I_ENABLE)
        for (int i = 0; i < NREGS; i++)
          if (I_REG_ENABLE[i]) regs_q[i] <= O_WRITE_PORT;
    end
  end

  assign O_FLAGS = flags_q;
endmodule

// File: tb/tb_cr16_datapath.sv
// Directed bench for cr16_datapath; stimulus queues expected values, a negedge monitor checks them.
module tb_cr16_datapath;
  import cr16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] ren = '0;
  logic [3:0]  opc = '0, asel = '0, bsel = '0;
  logic [15:0] imm = '0;
  logic        isel = 1'b0;
  logic [15:0] wp;
  logic [4:0]  flg;

  typedef struct {
    int          cyc;
    bit          is_fl;
    logic [15:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cr16_datapath dut (
    .I_CLK             (clk),
    .I_RESET           (rst),
    .I_ENABLE          (en),
    .I_REG_ENABLE      (ren),
    .I_OPCODE          (opc),
    .I_READ_PORT_A_SEL (asel),
    .I_READ_PORT_B_SEL (bsel),
    .I_IMMEDIATE       (imm),
    .I_IMM_SEL         (isel),
    .O_WRITE_PORT      (wp),
    .O_FLAGS           (flg)
  );

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = e.is_fl ? {11'b0, flg} : wp;
      nvec++;
      if (act !== e.val) begin
        nerr++;
        $display("FAIL %s (%s) @cyc %0d: got %h expected %h",
                 e.nm, e.is_fl ? "flags" : "wport", e.cyc, act, e.val);
      end
    end
  end

  task automatic step(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [15:0] im, input logic is, input logic [15:0] re,
                      input logic e, input logic [15:0] exp_wp, input string nm);
    @(posedge clk); #1;
    rst = 1'b0; opc = op; asel = a; bsel = b; imm = im; isel = is; ren = re; en = e;
    q.push_back('{cyc, 1'b0, exp_wp, nm});
  endtask

  // Flags after the edge that ends the current step.
  task automatic exp_flags(input logic [4:0] f, input string nm);
    q.push_back('{cyc + 1, 1'b1, {11'b0, f}, nm});
  endtask

  // Reset asserted alongside an enabled all-register write of 0x1234.
  task automatic rst_step(input string nm);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; ren = 16'hFFFF; opc = OP_MOV; isel = 1'b1; imm = 16'h1234;
    q.push_back('{cyc, 1'b0, 16'h1234, nm});
    exp_flags(5'h00, nm);
  endtask

  logic [15:0] fib [14] = '{16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
                            16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};

  initial begin
    rst_step("reset");
    step(OP_ADD, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, "add_after_reset");
    step(OP_MOV, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 16'h0000, "clear_all");
    exp_flags(5'h08, "clear_all");
    step(OP_MOV, 0, 0, 16'h0001, 1, 16'h0003, 1, 16'h0001, "load_r0_r1");
    exp_flags(5'h00, "load_r0_r1");
    for (int k = 0; k < 14; k++)
      step(OP_ADD, 4'(k), 4'(k + 1), 0, 0, 16'(1) << (k + 2), 1, fib[k], "fib");
    exp_flags(5'h00, "fib_last");
    step(OP_MOV, 0, 15, 0, 0, 0, 1, 16'd987, "read_r15");
    step(OP_MOV, 0, 7, 0, 0, 0, 1, 16'd21, "read_r7");

    step(OP_MOV, 0, 0, 16'h7FFF, 1, 16'h0001, 1, 16'h7FFF, "load_7fff");
    exp_flags(5'h00, "load_7fff");
    step(OP_ADD, 0, 0, 16'h0001, 1, 0, 1, 16'h8000, "add_ovf");
    exp_flags(5'h14, "add_ovf");
    step(OP_MOV, 0, 0, 16'hFFFF, 1, 16'h0001, 1, 16'hFFFF, "load_ffff");
    exp_flags(5'h14, "load_ffff");
    step(OP_ADD, 0, 0, 16'h0001, 1, 0, 1, 16'h0000, "add_carry");
    exp_flags(5'h09, "add_carry");

    step(OP_MOV, 0, 0, 16'h0003, 1, 16'h0001, 1, 16'h0003, "load_3");
    exp_flags(5'h01, "load_3");
    step(OP_CMP, 0, 0, 16'h0005, 1, 0, 1, 16'h0003, "cmp_3_5");
    exp_flags(5'h13, "cmp_3_5");
    step(OP_MOV, 0, 0, 0, 0, 0, 1, 16'h0003, "r0_after_cmp");
    exp_flags(5'h03, "r0_after_cmp");
    step(OP_SUB, 0, 0, 16'h0005, 1, 0, 1, 16'hFFFE, "sub_borrow");
    exp_flags(5'h13, "sub_borrow");
    step(4'd13, 0, 0, 16'h1111, 1, 16'h0020, 1, 16'h0000, "op13_wr_r5");
    exp_flags(5'h13, "op13_hold");
    step(OP_MOV, 0, 5, 0, 0, 0, 1, 16'h0000, "read_r5");
    exp_flags(5'h0B, "read_r5");
    step(OP_MOV, 0, 0, 16'h5555, 1, 16'hFFFF, 0, 16'h5555, "en_off");
    exp_flags(5'h0B, "en_off_hold");
    step(OP_MOV, 0, 15, 0, 0, 0, 1, 16'd987, "r15_kept");
    step(OP_MOV, 0, 0, 0, 0, 0, 1, 16'h0003, "r0_kept");

    step(OP_AND, 0, 0, 16'h0006, 1, 0, 1, 16'h0002, "and");
    step(OP_OR,  0, 0, 16'h0006, 1, 0, 1, 16'h0007, "or");
    step(OP_XOR, 0, 0, 16'h0006, 1, 0, 1, 16'h0005, "xor");
    step(OP_NOT, 0, 0, 0, 1, 0, 1, 16'hFFFC, "not");
    step(OP_LSH, 0, 0, 16'h0014, 1, 0, 1, 16'h0030, "lsh_low4");
    step(OP_RSH, 15, 0, 16'h0002, 1, 0, 1, 16'h00F6, "rsh");
    step(OP_MOV, 0, 0, 16'h8001, 1, 16'h0002, 1, 16'h8001, "load_r1");
    step(OP_ARSH, 1, 0, 16'h0004, 1, 0, 1, 16'hF800, "arsh");
    step(OP_RSH, 1, 0, 16'h0004, 1, 0, 1, 16'h0800, "rsh_neg");
    step(OP_LUI, 0, 0, 16'h12AB, 1, 0, 1, 16'hAB00, "lui");
    step(OP_MUL, 15, 0, 16'h0100, 1, 0, 1, 16'hDB00, "mul");
    step(4'd15, 15, 0, 16'h0100, 1, 0, 1, 16'h0000, "op15");

    rst_step("reset_mid");
    step(OP_MOV, 0, 15, 0, 0, 0, 1, 16'h0000, "r15_cleared");
    step(OP_ADD, 0, 1, 0, 0, 0, 1, 16'h0000, "add_cleared");

    @(posedge clk); #1;
    en = 1'b0; ren = '0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d expected entries never checked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cr16_datapath.md
CR16_DATAPATH -- requirements
Module: cr16_datapath

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 I_CLK  in  1  clock; all state updates on its rising edge.
REQ-003 I_RESET  in  1  synchronous, active-high reset.
REQ-004 I_ENABLE  in  1  global enable; 0 blocks every register and flag write.
REQ-005 I_REG_ENABLE  in  16  one-hot-style write enables; bit i writes register ri.
REQ-006 I_OPCODE  in  4  ALU operation select.
REQ-007 I_READ_PORT_A_SEL  in  4  register index for operand A.
REQ-008 I_READ_PORT_B_SEL  in  4  register index for operand B.
REQ-009 I_IMMEDIATE  in  16  immediate operand.
REQ-010 I_IMM_SEL  in  1  1 = operand B is I_IMMEDIATE; 0 = operand B is the register selected by I_READ_PORT_B_SEL.
REQ-011 O_WRITE_PORT  out  16  ALU result, which is also the register write data.
REQ-012 O_FLAGS  out  5  registered status: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.

Function
REQ-013 SHALL contain 16 x 16-bit registers r0..r15 with two combinational read ports, A and B.
REQ-014 O_WRITE_PORT SHALL be combinational from the current register contents, I_IMMEDIATE, I_IMM_SEL and I_OPCODE, with no added latency.
REQ-015 On a rising edge with I_ENABLE=1, every ri with I_REG_ENABLE[i]=1 SHALL load O_WRITE_PORT; multiple set bits write all selected registers.
REQ-016 A new register value SHALL be visible on the read ports and O_WRITE_PORT in the cycle after the write.
REQ-017 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 CMP (result=A); 3 AND; 4 OR; 5 XOR; 6 NOT A; 7 LSH A<<B[3:0]; 8 RSH logical A>>B[3:0]; 9 ARSH arithmetic A>>>B[3:0]; 10 MOV (result=B); 11 LUI (result={B[7:0],8'h00}); 12 MUL (low 16 bits of A*B); 13-15 reserved (result 0).
REQ-018 All arithmetic SHALL be 16-bit modulo 2^16.
REQ-019 Flags SHALL update on a rising edge only when I_ENABLE=1 and the opcode is 0-12; otherwise they hold.
REQ-020 For every non-CMP valid opcode: Z=(result==0), N=result[15].
REQ-021 ADD: C=carry out of bit 15; F=signed overflow.
REQ-022 SUB: C=borrow (A<B unsigned); F=signed overflow.
REQ-023 CMP: Z=(A==B); L=(A<B unsigned); N=(A<B signed).
REQ-024 Flags not named for an opcode SHALL hold their previous value.
REQ-025 Register writes and flag writes SHALL occur independently of each other; opcodes 13-15 still write 0 to any enabled register.

Reset
REQ-026 While I_RESET=1 at a rising edge, all 16 registers and O_FLAGS SHALL clear to 0, regardless of I_ENABLE and I_REG_ENABLE.
REQ-027 Reset SHALL take priority over a simultaneous write.
REQ-028 After reset, O_WRITE_PORT SHALL reflect the zero registers, e.g. ADD of r0,r1 gives 0.

Structure
REQ-029 Package cr16_pkg SHALL hold the opcode constants, flag bit indices, and data width (16) and register count (16).
REQ-030 The ALU (operations and flag computation) SHALL be one sub-module, cr16_alu; the register file and flag register SHALL be inline in cr16_datapath.

Verification
REQ-031 Reset, then write 0 to all registers; load 1 into r0 and r1 via I_IMM_SEL=1 with MOV. Then ADD with A=r(k), B=r(k+1) into r(k+2) for k=0..13 -> writes 2,3,5,8,...,987.
REQ-032 With r0=0x7FFF, ADD B-immediate 1 -> O_WRITE_PORT=0x8000 and, after the edge, F=1, N=1, C=0, Z=0.
REQ-033 With r0=0xFFFF, ADD immediate 1 -> result 0x0000 and, after the edge, C=1, Z=1.
REQ-034 CMP with r0=3 and immediate 5 -> L=1, N=1, Z=0; r0 is unchanged when I_REG_ENABLE=0.
REQ-035 With I_ENABLE=0 and I_REG_ENABLE=16'hFFFF -> no register or flag changes; asserting I_RESET mid-sequence -> all registers and flags are 0 on the next edge.
